// File: rtl/req_encoder_pkg.sv
// Shared types and width helper for the sequential request encoder.
package req_enc_pkg;

  typedef enum logic {IDLE, EMIT} state_t;

  // Index width for an n-bit vector, never less than one bit.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < n) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/req_encoder_if.sv
// Input/output handshake bundle between a request source/sink and req_encoder.
interface req_encoder_if import req_enc_pkg::*; #(
  parameter int N = 4
);
  localparam int W = clog2w(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         zero_err;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, zero_err
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, zero_err
  );
endinterface

// File: rtl/req_encoder_pri_enc.sv
// Lowest-set-bit priority encoder with a single-bit-set flag.
module pri_enc import req_enc_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_vec,
  output logic [clog2w(N)-1:0] o_idx,
  output logic                 o_onehot
);
  localparam int W = clog2w(N);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i_vec[i]) o_idx = W'(i);
  end

  assign o_onehot = (i_vec != '0) && ((i_vec & (i_vec - N'(1))) == '0);

endmodule

// File: rtl/req_encoder.sv
// Sequential N-to-log2(N) encoder: accepts a request vector and emits the index
// of each set bit, lowest first, one per output beat.
module req_encoder import req_enc_pkg::*; #(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  req_encoder_if.slave bus
);
  localparam int W = clog2w(N);

  state_t       r_state;
  logic [N-1:0] r_pend;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_zero_err;

  logic [W-1:0] w_idx;
  logic         w_onehot;
  logic         w_in_xfer;
  logic         w_out_xfer;

  // Index and last flag come only from the pend register, so no input reaches an output.
  pri_enc #(.N(N)) u_pri_enc (
    .i_vec    (r_pend),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_zero_err  <= 1'b0;
    end else begin
      r_zero_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_in_xfer) begin
            if (bus.in_vec != '0) begin
              r_pend      <= bus.in_vec;
              r_state     <= EMIT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_zero_err <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (w_out_xfer) begin
            r_pend <= r_pend & (r_pend - N'(1));
            if (w_onehot) begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_pend      <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_idx   = w_idx;
  assign bus.out_last  = w_onehot;
  assign bus.zero_err  = r_zero_err;

endmodule

// File: tb/tb_req_encoder.sv
// Directed bench for req_encoder with N=4.
module tb_req_encoder;

  logic clk;
  logic rst_n;

  req_encoder_if #(.N(4)) bus ();

  req_encoder #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector, wait (bounded) for in_ready, and let one edge accept it.
  task automatic send(input logic [3:0] vec, input string tag);
    int n;
    bus.in_valid = 1'b1;
    bus.in_vec   = vec;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_in_rdy"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic beat(input logic [1:0] idx, input logic last, input string tag);
    chk({tag, "_vld"},  32'(bus.out_valid), 32'd1);
    chk({tag, "_idx"},  32'(bus.out_idx),   32'(idx));
    chk({tag, "_last"}, 32'(bus.out_last),  32'(last));
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = 4'b0000;
    bus.out_ready = 1'b0;

    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_idx",   32'(bus.out_idx),   32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_zero_err",  32'(bus.zero_err),  32'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // T1
    bus.out_ready = 1'b1;
    send(4'b0001, "t1");
    beat(2'd0, 1'b1, "t1_b0");
    chk("t1_in_ready_busy", 32'(bus.in_ready), 32'd0);
    tick();
    chk("t1_done_vld",   32'(bus.out_valid), 32'd0);
    chk("t1_done_in_rdy", 32'(bus.in_ready), 32'd1);

    // T2
    send(4'b1010, "t2");
    beat(2'd1, 1'b0, "t2_b0");
    tick();
    beat(2'd3, 1'b1, "t2_b1");
    tick();
    chk("t2_done_vld", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t2_no_extra", 32'(bus.out_valid), 32'd0);

    // T3
    bus.out_ready = 1'b0;
    send(4'b1111, "t3");
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < 3; s++) begin
        beat(2'(b), (b == 3), $sformatf("t3_stall%0d_%0d", b, s));
        tick();
      end
      bus.out_ready = 1'b1;
      beat(2'(b), (b == 3), $sformatf("t3_b%0d", b));
      tick();
      bus.out_ready = 1'b0;
    end
    chk("t3_done_vld", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;

    // T4
    bus.in_valid = 1'b1;
    bus.in_vec   = 4'b0000;
    tick();
    bus.in_valid = 1'b0;
    chk("t4_zero_err", 32'(bus.zero_err), 32'd1);
    chk("t4_vld",      32'(bus.out_valid), 32'd0);
    chk("t4_in_rdy",   32'(bus.in_ready), 32'd1);
    tick();
    chk("t4_zero_err_end", 32'(bus.zero_err), 32'd0);
    chk("t4_vld_end",      32'(bus.out_valid), 32'd0);

    // T5
    send(4'b0011, "t5");
    bus.in_valid = 1'b1;
    bus.in_vec   = 4'b0100;
    beat(2'd0, 1'b0, "t5_b0");
    tick();
    beat(2'd1, 1'b1, "t5_b1");
    tick();
    chk("t5_idle_vld",   32'(bus.out_valid), 32'd0);
    chk("t5_idle_in_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    beat(2'd2, 1'b1, "t5_b2");
    tick();
    chk("t5_done_vld", 32'(bus.out_valid), 32'd0);

    // T6
    send(4'b1111, "t6");
    beat(2'd0, 1'b0, "t6_b0");
    tick();
    beat(2'd1, 1'b0, "t6_b1");
    tick();
    beat(2'd2, 1'b0, "t6_b2_pre");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_vld",  32'(bus.out_valid), 32'd0);
    chk("t6_async_idx",  32'(bus.out_idx),   32'd0);
    chk("t6_async_last", 32'(bus.out_last),  32'd0);
    chk("t6_async_rdy",  32'(bus.in_ready),  32'd0);
    tick();
    tick();
    #3 rst_n = 1'b1;
    tick();
    chk("t6_rel_in_rdy", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_no_residual%0d", i), 32'(bus.out_valid), 32'd0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
